// File: rtl/gpio_cfg_if.sv
// Bus bundle between the management side and the GPIO pad-config loader.
interface gpio_cfg_if #(
  parameter int unsigned NUM_PADS = 20,
  parameter int unsigned CFG_BITS = 13
);
  localparam int unsigned ADDR_W = $clog2(NUM_PADS);

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [CFG_BITS-1:0] wr_data;
  logic                wr_err;
  logic                start;
  logic                busy;
  logic                done;
  logic                ser_clk;
  logic                ser_data;
  logic                ser_load;

  // Management core / bench side.
  modport master (
    output wr_en, wr_addr, wr_data, start,
    input  wr_err, busy, done, ser_clk, ser_data, ser_load
  );

  // Loader side.
  modport slave (
    input  wr_en, wr_addr, wr_data, start,
    output wr_err, busy, done, ser_clk, ser_data, ser_load
  );
endinterface

// File: rtl/gpio_cfg_loader.sv
// Shadow config words for the user GPIO pads, shifted out serially on start.
module gpio_cfg_loader #(
  parameter int unsigned         NUM_PADS  = 20,
  parameter int unsigned         CFG_BITS  = 13,
  parameter int unsigned         CLK_DIV   = 4,
  parameter logic [CFG_BITS-1:0] RESET_CFG = CFG_BITS'(13'h0403)
) (
  input  logic       clk,
  input  logic       rst_n,
  gpio_cfg_if.slave  bus
);

  localparam int unsigned ADDR_W     = $clog2(NUM_PADS);
  localparam int unsigned BIT_W      = $clog2(CFG_BITS);
  localparam logic [7:0]  DIV_RELOAD = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    FINISH
  } state_t;

  state_t              state;
  logic [7:0]          div_cnt;
  logic [BIT_W-1:0]    bit_cnt;
  logic [ADDR_W-1:0]   pad_cnt;
  logic [CFG_BITS-1:0] shadow [NUM_PADS];

  logic busy_r;
  logic done_r;
  logic wr_err_r;
  logic ser_clk_r;
  logic ser_data_r;
  logic ser_load_r;

  logic              wr_ok_c;
  logic              last_bit_c;
  logic              last_pad_c;
  logic              div_zero_c;
  logic [BIT_W-1:0]  nxt_bit_c;
  logic [ADDR_W-1:0] nxt_pad_c;
  logic              first_bit_c;

  // Write qualification and next shift position.
  always_comb begin
    wr_ok_c     = bus.wr_en && (state == IDLE) && (32'(bus.wr_addr) < NUM_PADS);
    last_bit_c  = (bit_cnt == '0);
    last_pad_c  = (pad_cnt == '0);
    div_zero_c  = (div_cnt == 8'd0);
    nxt_bit_c   = last_bit_c ? BIT_W'(CFG_BITS - 1) : bit_cnt - BIT_W'(1);
    nxt_pad_c   = last_bit_c ? pad_cnt - ADDR_W'(1) : pad_cnt;
    // A write landing in the start cycle must already show up as the first bit.
    first_bit_c = shadow[NUM_PADS-1][CFG_BITS-1];
    if (wr_ok_c && (bus.wr_addr == ADDR_W'(NUM_PADS - 1))) begin
      first_bit_c = bus.wr_data[CFG_BITS-1];
    end
  end

  // Shadow word storage; only writable while idle, so a load sees a stable snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_PADS); i++) begin
        shadow[i] <= RESET_CFG;
      end
    end else if (wr_ok_c) begin
      shadow[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Load sequencer: half-period divider, bit/pad walk, latch strobe, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_cnt    <= 8'd0;
      bit_cnt    <= '0;
      pad_cnt    <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      wr_err_r   <= 1'b0;
      ser_clk_r  <= 1'b0;
      ser_data_r <= 1'b0;
      ser_load_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      wr_err_r <= bus.wr_en && !wr_ok_c;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= SHIFT_LO;
            busy_r     <= 1'b1;
            div_cnt    <= DIV_RELOAD;
            bit_cnt    <= BIT_W'(CFG_BITS - 1);
            pad_cnt    <= ADDR_W'(NUM_PADS - 1);
            ser_clk_r  <= 1'b0;
            ser_data_r <= first_bit_c;
          end
        end
        SHIFT_LO: begin
          if (div_zero_c) begin
            state     <= SHIFT_HI;
            div_cnt   <= DIV_RELOAD;
            ser_clk_r <= 1'b1;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SHIFT_HI: begin
          if (div_zero_c) begin
            div_cnt   <= DIV_RELOAD;
            ser_clk_r <= 1'b0;
            if (last_bit_c && last_pad_c) begin
              state      <= LOAD;
              ser_data_r <= 1'b0;
              ser_load_r <= 1'b1;
            end else begin
              state      <= SHIFT_LO;
              bit_cnt    <= nxt_bit_c;
              pad_cnt    <= nxt_pad_c;
              ser_data_r <= shadow[nxt_pad_c][nxt_bit_c];
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        LOAD: begin
          if (div_zero_c) begin
            state      <= FINISH;
            ser_load_r <= 1'b0;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.wr_err   = wr_err_r;
  assign bus.ser_clk  = ser_clk_r;
  assign bus.ser_data = ser_data_r;
  assign bus.ser_load = ser_load_r;

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// Bench for gpio_cfg_loader: CLK_DIV=4 instance for loads, CLK_DIV=1 instance for back-to-back.
`timescale 1ns/1ps
module tb_gpio_cfg_loader;

  localparam int unsigned NP    = 20;
  localparam int unsigned CB    = 13;
  localparam int unsigned AW    = $clog2(NP);
  localparam int unsigned NBITS = NP * CB;
  localparam logic [CB-1:0] RST_WORD = 13'h0403;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  gpio_cfg_if #(.NUM_PADS(NP), .CFG_BITS(CB)) bus_a ();
  gpio_cfg_if #(.NUM_PADS(NP), .CFG_BITS(CB)) bus_b ();

  gpio_cfg_loader #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(4), .RESET_CFG(RST_WORD)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  gpio_cfg_loader #(.NUM_PADS(NP), .CFG_BITS(CB), .CLK_DIV(1), .RESET_CFG(RST_WORD)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  int total = 0;
  int bad   = 0;

  logic [CB-1:0] model_a [NP];
  logic [CB-1:0] model_b [NP];

  // Capture results of one transfer on instance A.
  logic [NBITS-1:0] cap_bits;
  int   cap_n, first_rise, load_first, load_cnt, done_at, done_cnt, stab_err;
  logic busy1, werr1, werr2;
  logic [5:0] rst_outs;

  // Expected serial stream: pad NP-1 first, pad 0 last, each word MSB first.
  function automatic logic [NBITS-1:0] stream_of(input logic [CB-1:0] m [NP]);
    logic [NBITS-1:0] s;
    s = '0;
    for (int p = NP - 1; p >= 0; p--)
      for (int b = CB - 1; b >= 0; b--)
        s = {s[NBITS-2:0], m[p][b]};
    return s;
  endfunction

  task automatic write_a(input int addr, input logic [CB-1:0] data);
    bus_a.wr_en   = 1'b1;
    bus_a.wr_addr = AW'(addr);
    bus_a.wr_data = data;
    @(negedge clk);
    bus_a.wr_en = 1'b0;
    if (addr < int'(NP)) model_a[addr] = data;
  endtask

  // Start a load on A (caller may preset a same-cycle write) and observe for budget cycles.
  task automatic run_xfer_a(input int budget, input int wr_at, input bit poke_start, input int rst_at);
    logic prev_clk, prev_data;
    cap_bits = '0; cap_n = 0; first_rise = -1; load_first = -1; load_cnt = 0;
    done_at = -1; done_cnt = 0; stab_err = 0; busy1 = 1'b0; werr1 = 1'b0; werr2 = 1'b1;
    rst_outs = '1; prev_clk = 1'b0; prev_data = 1'b0;
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_a.wr_en = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      if (n == 1) busy1 = bus_a.busy;
      if (n == wr_at + 1) werr1 = bus_a.wr_err;
      if (n == wr_at + 2) werr2 = bus_a.wr_err;
      if (bus_a.ser_clk && !prev_clk) begin
        cap_n++;
        cap_bits = {cap_bits[NBITS-2:0], bus_a.ser_data};
        if (first_rise < 0) first_rise = n;
      end
      if (bus_a.ser_clk && prev_clk && (bus_a.ser_data !== prev_data)) stab_err++;
      if (bus_a.ser_load) begin
        load_cnt++;
        if (load_first < 0) load_first = n;
      end
      if (bus_a.done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      prev_clk  = bus_a.ser_clk;
      prev_data = bus_a.ser_data;
      bus_a.wr_en = (n == wr_at);
      if (n == wr_at) begin
        bus_a.wr_addr = AW'(3);
        bus_a.wr_data = ~model_a[3];
      end
      bus_a.start = poke_start && (n % 250 == 0) && (n < 2000);
      if (n == rst_at) begin
        #1 rst_n = 1'b0;
        #1 rst_outs = {bus_a.ser_clk, bus_a.ser_load, bus_a.busy, bus_a.done,
                       bus_a.ser_data, bus_a.wr_err};
      end
      if (n == rst_at + 3) rst_n = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({bus_a.ser_clk, bus_a.ser_load, bus_a.busy, bus_a.done, bus_a.ser_data, bus_a.wr_err} !== 6'b0) begin
      bad++; $display("FAIL reset_outs_a: got %b expected 000000",
        {bus_a.ser_clk, bus_a.ser_load, bus_a.busy, bus_a.done, bus_a.ser_data, bus_a.wr_err});
    end
    total++;
    if ({bus_b.ser_clk, bus_b.ser_load, bus_b.busy, bus_b.done, bus_b.ser_data, bus_b.wr_err} !== 6'b0) begin
      bad++; $display("FAIL reset_outs_b: got %b expected 000000",
        {bus_b.ser_clk, bus_b.ser_load, bus_b.busy, bus_b.done, bus_b.ser_data, bus_b.wr_err});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%b expected 0", bus_a.busy); end
  endtask

  task automatic test_default_load();
    run_xfer_a(2100, -10, 1'b0, -10);
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL busy_rise: got %b expected 1", busy1); end
    total++; if (cap_n != int'(NBITS)) begin bad++; $display("FAIL pulse_count: got %0d expected %0d", cap_n, NBITS); end
    total++; if (cap_bits !== stream_of(model_a)) begin
      bad++; $display("FAIL default_stream: got %h expected %h", cap_bits, stream_of(model_a)); end
    total++; if (first_rise != 5) begin bad++; $display("FAIL first_rise: got %0d expected 5", first_rise); end
    total++; if (load_first != 2081) begin bad++; $display("FAIL load_start: got %0d expected 2081", load_first); end
    total++; if (load_cnt != 4) begin bad++; $display("FAIL load_len: got %0d expected 4", load_cnt); end
    total++; if (done_at != 2085) begin bad++; $display("FAIL done_latency: got %0d expected 2085", done_at); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL done_count: got %0d expected 1", done_cnt); end
    total++; if (stab_err != 0) begin bad++; $display("FAIL data_stable: got %0d changes expected 0", stab_err); end
  endtask

  task automatic test_pattern();
    write_a(0, 13'h1FFF);
    // Pad 19 written in the same cycle start is raised.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = AW'(19); bus_a.wr_data = 13'h0001;
    model_a[19] = 13'h0001;
    run_xfer_a(2100, -10, 1'b0, -10);
    total++; if (cap_bits[NBITS-1 -: CB] !== 13'h0001) begin
      bad++; $display("FAIL first_word: got %h expected 0001", cap_bits[NBITS-1 -: CB]); end
    total++; if (cap_bits[CB-1:0] !== 13'h1FFF) begin
      bad++; $display("FAIL last_word: got %h expected 1fff", cap_bits[CB-1:0]); end
    total++; if (cap_bits !== stream_of(model_a)) begin
      bad++; $display("FAIL pattern_stream: got %h expected %h", cap_bits, stream_of(model_a)); end
  endtask

  task automatic test_bad_addr();
    write_a(25, 13'(($urandom)));
    total++; if (bus_a.wr_err !== 1'b1) begin bad++; $display("FAIL bad_addr_err: got %b expected 1", bus_a.wr_err); end
    @(negedge clk);
    total++; if (bus_a.wr_err !== 1'b0) begin bad++; $display("FAIL bad_addr_err_len: got %b expected 0", bus_a.wr_err); end
    run_xfer_a(2100, -10, 1'b0, -10);
    total++; if (cap_bits !== stream_of(model_a)) begin
      bad++; $display("FAIL bad_addr_stream: got %h expected %h", cap_bits, stream_of(model_a)); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 2; it++) begin
      for (int k = 0; k < 8; k++) begin
        int a;
        a = int'($urandom_range(0, NP - 1));
        write_a(a, 13'($urandom));
        total++; if (bus_a.wr_err !== 1'b0) begin bad++; $display("FAIL good_write_err: got %b expected 0", bus_a.wr_err); end
      end
      run_xfer_a(2100, -10, 1'b0, -10);
      total++; if (cap_bits !== stream_of(model_a)) begin
        bad++; $display("FAIL random_stream: got %h expected %h", cap_bits, stream_of(model_a)); end
      total++; if (done_at != 2085) begin bad++; $display("FAIL random_done: got %0d expected 2085", done_at); end
    end
  endtask

  task automatic test_busy();
    run_xfer_a(4200, 100, 1'b1, -10);
    total++; if (werr1 !== 1'b1) begin bad++; $display("FAIL busy_wr_err: got %b expected 1", werr1); end
    total++; if (werr2 !== 1'b0) begin bad++; $display("FAIL busy_wr_err_len: got %b expected 0", werr2); end
    total++; if (cap_bits !== stream_of(model_a)) begin
      bad++; $display("FAIL busy_stream: got %h expected %h", cap_bits, stream_of(model_a)); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_start_ignored: got %0d dones expected 1", done_cnt); end
    total++; if (done_at != 2085) begin bad++; $display("FAIL busy_done: got %0d expected 2085", done_at); end
  endtask

  task automatic test_reset_mid();
    write_a(7, 13'h1ABC);
    run_xfer_a(700, -10, 1'b0, 500);
    for (int p = 0; p < int'(NP); p++) model_a[p] = RST_WORD;
    total++; if (rst_outs !== 6'b0) begin bad++; $display("FAIL mid_reset_outs: got %b expected 000000", rst_outs); end
    total++; if (load_cnt != 0) begin bad++; $display("FAIL mid_reset_load: got %0d expected 0", load_cnt); end
    total++; if (done_cnt != 0) begin bad++; $display("FAIL mid_reset_done: got %0d expected 0", done_cnt); end
    run_xfer_a(2100, -10, 1'b0, -10);
    total++; if (cap_bits !== stream_of(model_a)) begin
      bad++; $display("FAIL post_reset_stream: got %h expected %h", cap_bits, stream_of(model_a)); end
  endtask

  // CLK_DIV=1, start held: one transfer is 1+520+1 cycles, then one IDLE cycle before the next.
  task automatic test_back_to_back();
    logic [NBITS-1:0] bits;
    int rises, tog_err, d1, d2, low_run;
    logic prev_clk, seen_busy, fell, counting;
    for (int p = 0; p < int'(NP); p++) model_b[p] = RST_WORD;
    bits = '0; rises = 0; tog_err = 0; d1 = -1; d2 = -1; low_run = 0;
    prev_clk = 1'b0; seen_busy = 1'b0; fell = 1'b0; counting = 1'b0;
    bus_b.start = 1'b1;
    @(negedge clk);
    for (int n = 1; n <= 1100; n++) begin
      if (n <= 522 && bus_b.ser_clk && !prev_clk) begin
        rises++;
        bits = {bits[NBITS-2:0], bus_b.ser_data};
      end
      if (n <= 520 && (bus_b.ser_clk !== ((n % 2) == 0))) tog_err++;
      if (bus_b.done) begin
        if (d1 < 0) d1 = n;
        else if (d2 < 0) d2 = n;
      end
      if (bus_b.busy) begin
        seen_busy = 1'b1;
        if (counting) begin counting = 1'b0; fell = 1'b1; end
      end else if (seen_busy && !fell) begin
        counting = 1'b1;
        low_run++;
      end
      prev_clk = bus_b.ser_clk;
      @(negedge clk);
    end
    bus_b.start = 1'b0;
    total++; if (rises != int'(NBITS)) begin bad++; $display("FAIL b2b_pulses: got %0d expected %0d", rises, NBITS); end
    total++; if (tog_err != 0) begin bad++; $display("FAIL b2b_toggle: got %0d errors expected 0", tog_err); end
    total++; if (bits !== stream_of(model_b)) begin
      bad++; $display("FAIL b2b_stream: got %h expected %h", bits, stream_of(model_b)); end
    total++; if (d1 != 522) begin bad++; $display("FAIL b2b_done1: got %0d expected 522", d1); end
    total++; if (d2 != 1045) begin bad++; $display("FAIL b2b_done2: got %0d expected 1045", d2); end
    total++; if (low_run != 2) begin bad++; $display("FAIL b2b_busy_gap: got %0d expected 2", low_run); end
  endtask

  initial begin
    bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0; bus_a.start = 1'b0;
    bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0; bus_b.start = 1'b0;
    for (int p = 0; p < int'(NP); p++) model_a[p] = RST_WORD;
    test_reset();
    test_default_load();
    test_pattern();
    test_bad_addr();
    test_random();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
